// File: rtl/seg_pair_decoder.sv
// seg_pair_decoder: recovers a byte from a two-digit multiplexed seven-segment bus.
// Define SEG_DP_CHECK_EN to reject patterns with the decimal point lit.
module seg_pair_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_bus,
  input  logic [1:0] digit_sel,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       pattern_error,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, HALF, EMIT} state_t;
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);
  localparam logic [7:0] SC1 = 8'(STABLE_CYCLES - 1);
  state_t state;
  logic [9:0] prev;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] n1, n2, nn1, nn2, nib;
  logic have1, have2, h1, h2, one_hot, changed, accept, glyph, ok, emit;
  always_comb begin
    one_hot = (digit_sel == 2'b01) || (digit_sel == 2'b10);
    changed = {digit_sel, seg_bus} != prev;
    cnt_nxt = !one_hot ? 8'd0 : changed ? 8'd1 : (cnt == SC) ? cnt : cnt + 8'd1;
    accept = one_hot && !changed && cnt == SC1;
    glyph = 1'b1;
    nib = 4'h0;
    case (seg_bus[6:0])
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: glyph = 1'b0;
    endcase
`ifdef SEG_DP_CHECK_EN
    ok = glyph && !seg_bus[7];
`else
    ok = glyph;
`endif
    h1 = have1 || (accept && ok && digit_sel[0]);
    h2 = have2 || (accept && ok && digit_sel[1]);
    nn1 = (accept && digit_sel[0]) ? nib : n1;
    nn2 = (accept && digit_sel[1]) ? nib : n2;
    emit = h1 && h2;
  end
  // Flags carry the pending state; the enum mirrors them and marks the emit cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
      cnt <= '0;
      n1 <= '0;
      n2 <= '0;
      have1 <= 1'b0;
      have2 <= 1'b0;
      value <= '0;
      value_valid <= 1'b0;
      pattern_error <= 1'b0;
      busy <= 1'b0;
      state <= IDLE;
    end else begin
      prev <= {digit_sel, seg_bus};
      cnt <= cnt_nxt;
      value_valid <= 1'b0;
      pattern_error <= 1'b0;
      if (accept && !ok) begin
        pattern_error <= 1'b1;
        have1 <= 1'b0;
        have2 <= 1'b0;
        n1 <= '0;
        n2 <= '0;
        busy <= 1'b0;
        state <= IDLE;
      end else begin
        n1 <= nn1;
        n2 <= nn2;
        have1 <= h1 && !emit;
        have2 <= h2 && !emit;
        busy <= h1 ^ h2;
        state <= emit ? EMIT : (h1 ^ h2) ? HALF : IDLE;
        if (emit) begin
          value <= {nn1, nn2};
          value_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/seg_pair_decoder.md
# seg_pair_decoder

Recovers an 8-bit value from a multiplexed two-digit seven-segment display bus, reversing the hex-to-seven-segment encoding used by the display path. It samples a shared segment bus with a one-hot digit select, requires each pattern to be stable before accepting it, and decodes it to a nibble. When both digits have been accepted it emits the byte with a one-cycle valid pulse. It sits on the loopback/self-check side of the display subsystem, watching the same bus that drives the panel.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required to accept a digit; legal range 2..255.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- SegBus  input  8  segment pattern, bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a; 1 = segment lit.
- DigitSel  input  2  one-hot digit select: 2'b01 = Dig1 (high nibble), 2'b10 = Dig2 (low nibble); 00/11 = blanked.
- Value  output  8  last assembled byte, {Dig1 nibble, Dig2 nibble}.
- ValueValid  output  1  one-cycle pulse when Value updates.
- PatternError  output  1  one-cycle pulse when an accepted pattern is not a legal hex glyph.
- Busy  output  1  high while exactly one digit is pending.

## Operation
- Glyph table (SegBus[6:0]): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Any other value is invalid.
- Sample registers hold the previous {DigitSel, SegBus}. StableCnt (8 bit) behaviour:
  - Reset to 1 on any change of the sample.
  - Held at 0 while DigitSel is not one-hot.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Accept: on the cycle StableCnt reaches STABLE_CYCLES, that pattern is accepted exactly once. It is not re-accepted until the sample changes.
- Pending flags Have1/Have2 and nibble registers N1/N2. A valid accept:
  - writes the nibble for the selected digit and sets its flag;
  - re-accepting an already pending digit overwrites its nibble.
- When both flags are set after an accept:
  - Value <= {N1,N2} (including the nibble just accepted) and ValueValid pulses;
  - both flags clear.
- Invalid accept: PatternError pulses, both flags and both nibbles clear, and Value is unchanged.
- FSM states, encoded by the flags:
  - IDLE (none pending): valid accept -> HALF.
  - HALF (one pending): accept of the other digit -> EMIT. Same digit stays in HALF. Invalid accept -> IDLE.
  - EMIT: single cycle, ValueValid = 1 -> IDLE.
- Busy = 1 only in HALF.

## Timing
- Reset values: Value = 8'h00, ValueValid = 0, PatternError = 0, Busy = 0. Sample registers, counter, flags and nibbles are all zero.
- Latency: pattern first sampled at edge k and held through edge k+STABLE_CYCLES-1. Accept is registered at that last edge, so ValueValid/PatternError are high for the following cycle only.
- Each digit must persist for at least STABLE_CYCLES samples. Shorter dwell is ignored (glitch filter).
- A change at the edge where the count would saturate cancels the accept.
- DigitSel blanking between digits is allowed and does not clear pending flags.
- Reset asserted mid-collection clears everything immediately, asynchronously. No pulse is produced on reset release.
- No back-pressure: a consumer must take Value on the ValueValid cycle; Value holds until the next emit.

## Configuration
- SEG_DP_CHECK_EN defined: a pattern with SegBus[7] = 1 is invalid and gives PatternError.
- Not defined: SegBus[7] is ignored and only bits 6:0 are decoded.

## Test plan
- Dig1 = 00111001 for 4 cycles, then Dig2 = 01111101 for 4 cycles (STABLE_CYCLES = 4) -> ValueValid pulses once, Value = 8'hC6, Busy high between the two accepts.
- Dig1 = 8'h06 for 3 cycles then a change -> no accept. Then Dig1 = 8'h06 for 10 cycles and Dig2 = 8'h3F for 4 cycles -> exactly one ValueValid, Value = 8'h10.
- Dig1 = 8'h66, then Dig1 = 8'h71, then Dig2 = 8'h5E, each held 4 cycles -> Value = 8'hFD (overwrite of pending digit).
- Dig1 = 8'h7F accepted, then Dig2 = 8'h00 for 4 cycles -> PatternError pulse, Busy = 0, Value unchanged.
- Dig1 = 8'hB9 held 4 cycles: with SEG_DP_CHECK_EN -> PatternError. Without it -> accepted as C.
- Reset asserted in HALF after Dig1 accept -> all outputs 0 at once. A subsequent lone Dig2 accept produces no ValueValid.
